// File: rtl/fsic_gpio_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fsic_gpio_bank_ctrl
// Description : Multi-channel gpiov2 pad controller with break-before-make
//               direction turnaround, debounced input and sticky edge IRQs.
// Revision    : 1.0 - initial release
// ============================================================================
module fsic_gpio_bank_ctrl #(
  parameter int NUM_CH   = 8,
  parameter int DEB_W    = 4,
  parameter int DEB_CYC  = 4,
  parameter int TURN_CYC = 2
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset_n,
  input  logic [NUM_CH-1:0]     cfg_we,
  input  logic [3*NUM_CH-1:0]   cfg_dm,
  input  logic [NUM_CH-1:0]     out_data,
  input  logic [NUM_CH-1:0]     irq_mask,
  input  logic [NUM_CH-1:0]     irq_clr,
  input  logic [NUM_CH-1:0]     pad_in,
  output logic [NUM_CH-1:0]     pad_out,
  output logic [3*NUM_CH-1:0]   pad_dm,
  output logic [NUM_CH-1:0]     in_data,
  output logic [NUM_CH-1:0]     rise_sts,
  output logic [NUM_CH-1:0]     fall_sts,
  output logic                  irq
);

  localparam logic [2:0] c_dm_in  = 3'b001;
  localparam logic [2:0] c_dm_pu  = 3'b010;
  localparam logic [2:0] c_dm_pd  = 3'b011;
  localparam logic [2:0] c_dm_out = 3'b110;

  localparam int c_turn_w = (TURN_CYC < 2) ? 1 : $clog2(TURN_CYC + 1);
  localparam logic [c_turn_w-1:0] c_turn_load = c_turn_w'(TURN_CYC);
  localparam logic [c_turn_w-1:0] c_turn_one  = c_turn_w'(1);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_TURN = 1'b1
  } turn_state_t;

  logic [NUM_CH-1:0] w_sts_masked;
  logic              r_irq;

  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [2:0]          w_dm_req;
    logic [2:0]          w_dm_legal;
    logic [2:0]          r_dm;
    turn_state_t         r_state;
    turn_state_t         w_state_nxt;
    logic [c_turn_w-1:0] r_turn_cnt;
    logic [c_turn_w-1:0] w_turn_cnt_nxt;
    logic                w_dir_change;
    logic                w_run;
    logic                w_run_in;
    logic                r_out;
    logic                r_sync1;
    logic                w_in_nxt;
    logic                r_in;
    logic                r_rise;
    logic                r_fall;
    logic                w_rise_set;
    logic                w_fall_set;

    assign w_dm_req = cfg_dm[3*gi +: 3];

    always_comb begin
      w_dm_legal = c_dm_in;
      case (w_dm_req)
        c_dm_in, c_dm_pu, c_dm_pd, c_dm_out: w_dm_legal = w_dm_req;
        default:                             w_dm_legal = c_dm_in;
      endcase
    end

    // Only a change of direction class needs the safe-input turnaround window.
    assign w_dir_change = cfg_we[gi] &
                          ((w_dm_legal == c_dm_out) != (r_dm == c_dm_out));

    always_comb begin
      w_state_nxt    = r_state;
      w_turn_cnt_nxt = r_turn_cnt;
      if (w_dir_change) begin
        w_state_nxt    = ST_TURN;
        w_turn_cnt_nxt = c_turn_load;
      end else if (r_state == ST_TURN) begin
        if (r_turn_cnt <= c_turn_one) begin
          w_state_nxt    = ST_RUN;
          w_turn_cnt_nxt = '0;
        end else begin
          w_turn_cnt_nxt = r_turn_cnt - c_turn_one;
        end
      end
    end

    always_ff @(posedge axi_clk) begin
      if (!axi_reset_n) begin
        r_dm       <= c_dm_in;
        r_state    <= ST_RUN;
        r_turn_cnt <= '0;
        r_out      <= 1'b0;
      end else begin
        if (cfg_we[gi]) begin
          r_dm <= w_dm_legal;
        end
        r_state    <= w_state_nxt;
        r_turn_cnt <= w_turn_cnt_nxt;
        r_out      <= out_data[gi];
      end
    end

    assign w_run              = (r_state == ST_RUN);
    assign w_run_in           = w_run & (r_dm != c_dm_out);
    assign pad_dm[3*gi +: 3]  = w_run ? r_dm : c_dm_in;
    assign pad_out[gi]        = r_out & w_run & (r_dm == c_dm_out);

    always_ff @(posedge axi_clk) begin
      if (!axi_reset_n) begin
        r_sync1 <= 1'b0;
      end else begin
        r_sync1 <= pad_in[gi];
      end
    end

    if (DEB_CYC == 0) begin : g_deb_bypass
      // r_in itself acts as the second synchroniser stage.
      assign w_in_nxt = r_sync1;
    end else begin : g_deb
      localparam logic [DEB_W-1:0] c_deb_last = DEB_W'(DEB_CYC - 1);
      localparam logic [DEB_W-1:0] c_deb_one  = DEB_W'(1);

      logic             r_sync2;
      logic [DEB_W-1:0] r_deb_cnt;
      logic             w_accept;

      assign w_accept = (r_sync2 != r_in) && (r_deb_cnt == c_deb_last);

      always_ff @(posedge axi_clk) begin
        if (!axi_reset_n) begin
          r_sync2   <= 1'b0;
          r_deb_cnt <= '0;
        end else begin
          r_sync2 <= r_sync1;
          if ((r_sync2 == r_in) || w_accept) begin
            r_deb_cnt <= '0;
          end else begin
            r_deb_cnt <= r_deb_cnt + c_deb_one;
          end
        end
      end

      assign w_in_nxt = w_accept ? r_sync2 : r_in;
    end

    // Edges are qualified by the pre-edge channel state, so a transition that
    // lands while driving or turning around never raises status.
    assign w_rise_set = w_run_in & ~r_in &  w_in_nxt;
    assign w_fall_set = w_run_in &  r_in & ~w_in_nxt;

    always_ff @(posedge axi_clk) begin
      if (!axi_reset_n) begin
        r_in   <= 1'b0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_in   <= w_in_nxt;
        r_rise <= w_rise_set | (r_rise & ~irq_clr[gi]);
        r_fall <= w_fall_set | (r_fall & ~irq_clr[gi]);
      end
    end

    assign in_data[gi]      = r_in;
    assign rise_sts[gi]     = r_rise;
    assign fall_sts[gi]     = r_fall;
    assign w_sts_masked[gi] = (r_rise | r_fall) & irq_mask[gi];
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |w_sts_masked;
    end
  end

  assign irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_fsic_gpio_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsic_gpio_bank_ctrl
// Description : Scoreboard bench for fsic_gpio_bank_ctrl with a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsic_gpio_bank_ctrl;

  localparam int NUM_CH   = 8;
  localparam int DEB_W    = 4;
  localparam int DEB_CYC  = 4;
  localparam int TURN_CYC = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NUM_CH-1:0]   cfg_we, out_data, irq_mask, irq_clr, pad_in;
  logic [3*NUM_CH-1:0] cfg_dm;
  logic [NUM_CH-1:0]   pad_out, in_data, rise_sts, fall_sts;
  logic [3*NUM_CH-1:0] pad_dm;
  logic                irq;

  always #5 clk = ~clk;

  fsic_gpio_bank_ctrl #(
    .NUM_CH(NUM_CH), .DEB_W(DEB_W), .DEB_CYC(DEB_CYC), .TURN_CYC(TURN_CYC)
  ) dut (
    .axi_clk(clk), .axi_reset_n(rst_n), .cfg_we(cfg_we), .cfg_dm(cfg_dm),
    .out_data(out_data), .irq_mask(irq_mask), .irq_clr(irq_clr),
    .pad_in(pad_in), .pad_out(pad_out), .pad_dm(pad_dm), .in_data(in_data),
    .rise_sts(rise_sts), .fall_sts(fall_sts), .irq(irq)
  );

  typedef struct {
    logic [NUM_CH-1:0]   pad_out;
    logic [3*NUM_CH-1:0] pad_dm;
    logic [NUM_CH-1:0]   in_data;
    logic [NUM_CH-1:0]   rise;
    logic [NUM_CH-1:0]   fall;
    logic                irq;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: direction turnaround as "cycles left", input path as a
  // pad sample delay line plus a run length of disagreeing samples.
  logic [2:0] m_dm   [NUM_CH];
  int         m_left [NUM_CH];
  bit         m_d1   [NUM_CH];
  bit         m_d2   [NUM_CH];
  int         m_runl [NUM_CH];
  bit         m_in   [NUM_CH];
  bit         m_rise [NUM_CH];
  bit         m_fall [NUM_CH];
  bit         m_out  [NUM_CH];
  bit         m_irq;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_dm[c] = 3'b001; m_left[c] = 0; m_d1[c] = 0; m_d2[c] = 0;
      m_runl[c] = 0; m_in[c] = 0; m_rise[c] = 0; m_fall[c] = 0; m_out[c] = 0;
    end
    m_irq = 0;
  endtask

  // Advance the model across the coming rising edge and queue the expectation.
  task automatic tick();
    exp_t e;
    bit   any;
    if (!rst_n) begin
      model_reset();
    end else begin
      any = 0;
      for (int c = 0; c < NUM_CH; c++)
        if ((m_rise[c] || m_fall[c]) && irq_mask[c]) any = 1;
      for (int c = 0; c < NUM_CH; c++) begin
        bit         listening;
        bit         sample;
        bit         nxt;
        logic [2:0] req;
        listening = (m_left[c] == 0) && (m_dm[c] != 3'b110);
        sample    = m_d2[c];
        nxt       = m_in[c];
        if (DEB_CYC == 0) begin
          nxt = m_d1[c];
        end else if (sample != m_in[c]) begin
          m_runl[c]++;
          if (m_runl[c] == DEB_CYC) begin
            nxt = sample;
            m_runl[c] = 0;
          end
        end else begin
          m_runl[c] = 0;
        end
        m_rise[c] = (listening && !m_in[c] && nxt) || (m_rise[c] && !irq_clr[c]);
        m_fall[c] = (listening && m_in[c] && !nxt) || (m_fall[c] && !irq_clr[c]);
        m_in[c]   = nxt;
        m_d2[c]   = m_d1[c];
        m_d1[c]   = pad_in[c];
        req = cfg_dm[3*c +: 3];
        if (!(req inside {3'b001, 3'b010, 3'b011, 3'b110})) req = 3'b001;
        if (cfg_we[c] && ((req == 3'b110) != (m_dm[c] == 3'b110)))
          m_left[c] = TURN_CYC;
        else if (m_left[c] > 0)
          m_left[c]--;
        if (cfg_we[c]) m_dm[c] = req;
        m_out[c] = out_data[c];
      end
      m_irq = any;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      e.pad_dm[3*c +: 3] = (m_left[c] > 0) ? 3'b001 : m_dm[c];
      e.pad_out[c] = m_out[c] && (m_left[c] == 0) && (m_dm[c] == 3'b110);
      e.in_data[c] = m_in[c];
      e.rise[c]    = m_rise[c];
      e.fall[c]    = m_fall[c];
    end
    e.irq = m_irq;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: the DUT presents a fresh output set after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pad_dm",   64'(pad_dm),   64'(e.pad_dm));
        chk("pad_out",  64'(pad_out),  64'(e.pad_out));
        chk("in_data",  64'(in_data),  64'(e.in_data));
        chk("rise_sts", 64'(rise_sts), 64'(e.rise));
        chk("fall_sts", 64'(fall_sts), 64'(e.fall));
        chk("irq",      64'(irq),      64'(e.irq));
      end
    end
  end

  task automatic wr_dm(input int c, input logic [2:0] dm);
    cfg_we[c] = 1'b1;
    cfg_dm[3*c +: 3] = dm;
    tick();
    cfg_we[c] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst_n = 0; cfg_we = '0; cfg_dm = {NUM_CH{3'b001}}; out_data = '0;
    irq_mask = '0; irq_clr = '0; pad_in = '0;
    model_reset();
    @(negedge clk);
    idle(3);
    rst_n = 1;
    idle(10);

    // ch0 input -> output turnaround with data already present
    out_data[0] = 1'b1;
    wr_dm(0, 3'b110);
    idle(4);

    // ch1 same-class rewrites, then an illegal code
    wr_dm(1, 3'b010); idle(1);
    wr_dm(1, 3'b011); idle(1);
    wr_dm(1, 3'b111); idle(2);

    // ch2 glitch rejection, then a real rising edge
    irq_mask = '1;
    pad_in[2] = 1'b1; idle(3);
    pad_in[2] = 1'b0; idle(6);
    pad_in[2] = 1'b1; idle(10);

    // clear lands on the edge where the fall is detected
    pad_in[2] = 1'b0; idle(5);
    irq_clr[2] = 1'b1; tick(); irq_clr[2] = 1'b0;
    idle(3);
    irq_clr[2] = 1'b1; tick(); irq_clr[2] = 1'b0;
    idle(3);

    // ch3 output mode ignores input edges; reset lands mid-turnaround
    wr_dm(3, 3'b110); idle(4);
    for (int k = 0; k < 4; k++) begin
      pad_in[3] = ~pad_in[3];
      idle(8);
    end
    wr_dm(3, 3'b001);
    rst_n = 0; tick(); rst_n = 1;
    idle(4);

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cfg_we[c] = ($urandom_range(0, 9) == 0);
        cfg_dm[3*c +: 3] = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 5) == 0) pad_in[c] = ~pad_in[c];
        irq_clr[c] = ($urandom_range(0, 19) == 0);
      end
      out_data = NUM_CH'($urandom);
      if ($urandom_range(0, 31) == 0) irq_mask = NUM_CH'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    cfg_we = '0; irq_clr = '0; rst_n = 1;
    idle(12);

    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fsic_gpio_bank_ctrl.md
Name: fsic_gpio_bank_ctrl

Overview:
- Parametrised, multi-channel GPIO pad controller. It sits between the FSIC user-project logic and an array of gpiov2 pad wrappers.
- Per channel it holds a registered drive mode (DM) and applies break-before-make turnaround on direction changes.
- The pad input path is synchronised and debounced, then fed to edge detection with sticky, maskable interrupt status.
- One bank instance replaces hand-wired per-pad DM/OE tie-offs.

Parameters:
- NUM_CH, 8, number of pad channels.
- DEB_W, 4, width of the debounce counter.
- DEB_CYC, 4, consecutive stable cycles required to accept an input change; 0 = bypass. Must be < 2^DEB_W.
- TURN_CYC, 2, cycles the pad is held in safe input mode (3'b001) on an input<->output direction change; minimum 1.

Ports:
- axi_clk  in  1  system clock.
- axi_reset_n  in  1  synchronous, active-low reset.
- cfg_we  in  NUM_CH  per-channel DM write strobe.
- cfg_dm  in  3*NUM_CH  requested DM; channel i uses bits [3i+2:3i].
- out_data  in  NUM_CH  data to drive in output mode.
- irq_mask  in  NUM_CH  per-channel interrupt enable, 1 = enabled.
- irq_clr  in  NUM_CH  write-1-to-clear for both rise and fall status bits.
- pad_in  in  NUM_CH  pad IN pins (asynchronous).
- pad_out  out  NUM_CH  to pad OUT.
- pad_dm  out  3*NUM_CH  to pad DM.
- in_data  out  NUM_CH  debounced input value.
- rise_sts  out  NUM_CH  sticky rising-edge status.
- fall_sts  out  NUM_CH  sticky falling-edge status.
- irq  out  1  level interrupt.

Behaviour:
- All state is reset synchronously when axi_reset_n = 0 at a rising edge of axi_clk.
- Reset values:
  - dm_q = 3'b001 for every channel; pad_dm = 3'b001.
  - pad_out = 0, in_data = 0, rise_sts = 0, fall_sts = 0, irq = 0.
  - Synchroniser flops = 0; debounce and turnaround counters = 0.
- Legal DM codes: 001 input, 010 input with pull-up, 011 input with pull-down, 110 output.
  - cfg_we[i] = 1 loads dm_q[i] the next cycle.
  - Any other code loads 3'b001.
- Direction class: output if dm_q = 110, else input.
- Per-channel turnaround state machine:
  - States: RUN (pad_dm = dm_q) and TURN (pad_dm = 3'b001).
  - A write that changes direction class moves RUN->TURN and loads the counter with TURN_CYC.
  - In TURN the counter decrements each cycle; at 0 the state returns to RUN.
  - A write within the same class takes effect on pad_dm the cycle after cfg_we, with no TURN.
  - A write during TURN updates dm_q and restarts the counter at TURN_CYC if the class changes again.
- pad_out[i] = out_data[i] registered (1-cycle latency). It is forced to 0 unless the channel is in RUN with dm_q = 110.
- Input path: 2-flop synchroniser on pad_in[i] feeds a debounce counter.
  - When the synchronised value equals in_data[i], the counter is cleared.
  - Otherwise the counter increments. When it reaches DEB_CYC-1, in_data[i] takes the synchronised value next cycle and the counter clears.
  - Net latency from a stable pad_in change to in_data: 2 + DEB_CYC cycles.
  - DEB_CYC = 0: in_data = synchronised value, latency 2.
- Edge detection:
  - A 0->1 transition of in_data[i] sets rise_sts[i]; 1->0 sets fall_sts[i].
  - Edges are detected only while the channel is in RUN with an input-class DM. Edges in output mode or TURN are ignored.
- irq_clr[i] clears both status bits for channel i. If set and clear coincide in the same cycle, set wins.
- irq = OR over i of ((rise_sts[i] | fall_sts[i]) & irq_mask[i]), registered (1 cycle after the status change).
- irq_mask does not gate the status bits, only irq.
- Reset asserted mid-turnaround or mid-debounce returns all channels to RUN with DM 001 immediately.

Test Plan:
- Reset, then idle 10 cycles -> every pad_dm = 001, pad_out = 0, irq = 0, in_data = 0.
- ch0: write DM 110 with out_data[0] = 1 (TURN_CYC = 2) -> pad_dm[0] = 001 for 2 cycles, then 110; pad_out[0] = 1 only from the first RUN cycle.
- ch1: write 010, then 011 -> pad_dm[1] updates the cycle after each write with no TURN. Then write illegal 111 -> pad_dm[1] = 001.
- ch2 input, DEB_CYC = 4, mask = 1: pad_in high for 3 cycles then low -> no change. pad_in held high -> in_data[2] = 1 exactly 6 cycles after the edge; rise_sts[2] = 1; irq = 1 one cycle later.
- irq_clr[2] asserted in the same cycle a fall edge sets fall_sts[2] -> fall_sts[2] = 1, rise_sts[2] = 0, irq stays 1. A second clear drops irq the following cycle.
- ch3 in output mode: toggle pad_in -> in_data follows but rise_sts/fall_sts stay 0. Assert reset during a TURN on ch3 -> pad_dm[3] = 001 next cycle, counter cleared.
